digits_timer: RTL and testbench
===============================

DIGITS_TIMER -- requirements
Module: digits_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 7, giving the count register width in bits.
REQ-002 SHALL have parameter MAX, default 99, giving the terminal count; MAX < 2^WIDTH and MAX >= 1.
REQ-003 SHALL have parameter BUZZ_CYCLES, default 1, giving the alarm length in clocks; BUZZ_CYCLES >= 1.
REQ-004 SHALL have port clk_1Hz, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port result_reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port updown, input, 1 bit: 0 = count up, 1 = count down.
REQ-007 SHALL have port result_load, input, 1 bit: load request, sampled every clock.
REQ-008 SHALL have port load_val, input, WIDTH bits: value written on load.
REQ-009 SHALL have port state, input, 1 bit: 1 = stop (hold), 0 = run.
REQ-010 SHALL have port count, output, WIDTH bits: registered current count.
REQ-011 SHALL have port buzzer, output, 1 bit: registered, high throughout ALARM.
REQ-012 SHALL have port wrap, output, 1 bit: registered single-clock pulse on each rollover.

Function
REQ-013 SHALL implement three states: RUN, HOLD, ALARM.
REQ-014 SHALL apply this per-clock priority: reset, then load, then ALARM timing, then stop, then count.
REQ-015 RUN, up mode: count < MAX gives count+1; count == MAX gives 0, wrap=1, enter ALARM.
REQ-016 RUN, down mode: count > 0 gives count-1; count == 0 gives MAX, wrap=1, enter ALARM.
REQ-017 ALARM: buzzer=1 and count frozen for exactly BUZZ_CYCLES clocks after the rollover edge, then buzzer=0.
REQ-018 On leaving ALARM, next state SHALL be HOLD if state=1, else RUN; state is ignored while in ALARM.
REQ-019 RUN moves to HOLD on the edge where state=1; HOLD moves to RUN on the edge where state=0; count is unchanged on both edges.
REQ-020 On load (result_load=1), count SHALL become min(load_val, MAX) on the next edge, in any state.
REQ-021 Load during ALARM SHALL abort it: buzzer=0 next edge; next state chosen by state as in REQ-018.
REQ-022 Load SHALL never generate wrap or ALARM, even when the loaded value equals a terminal count.
REQ-023 A change of updown SHALL take effect on the next counting edge, without modifying count.
REQ-024 wrap SHALL be high for exactly one clock per rollover, in the same cycle count shows the wrapped value.
REQ-025 count SHALL never exceed MAX; all arithmetic is WIDTH bits.

Reset
REQ-026 While result_reset_n=0 at an edge: count = MAX if updown=1, else 0.
REQ-027 The same reset edge SHALL also set buzzer=0, wrap=0, state machine to RUN, and clear the alarm counter.
REQ-028 Reset mid-ALARM SHALL clear buzzer on that edge; reset SHALL override a simultaneous load.

Configuration
REQ-029 Macro DIGITS_TIMER_BCD_OUT_EN defined: add output ports tens[3:0] and ones[3:0].
REQ-030 With the macro defined, tens and ones are registered, equal count/10 and count%10, and update on the same edge as count; reset gives the BCD of the reset count; valid only for MAX <= 99.
REQ-031 Macro undefined: tens and ones ports and their logic are absent; all other behaviour is identical.

Verification
REQ-032 Defaults, updown=0, count=98, state=0: two clocks -> count 99, then 0 with wrap=1 and buzzer=1; next clock buzzer=0, count 0; following clock count 1.
REQ-033 Defaults, updown=1, reset -> count 99; load load_val=1, then run two clocks -> 0, then 99 with wrap=1.
REQ-034 BUZZ_CYCLES=3: rollover -> buzzer high 3 clocks with count frozen; state=1 during ALARM -> HOLD after, count frozen.
REQ-035 load_val=120 with MAX=99 -> count 99, no wrap; load asserted during ALARM -> buzzer 0 next edge, count = loaded value.
REQ-036 state=1 at count 42 for 5 clocks -> count stays 42; reset asserted with result_load=1 -> count 0 (updown=0).
REQ-037 With DIGITS_TIMER_BCD_OUT_EN defined, count 57 -> tens 5, ones 7; rollover 99->0 -> tens 0, ones 0 on the same edge.

Source files
------------

// File: rtl/digits_timer.sv
// Up/down digit timer with load, hold and a fixed-length alarm after each rollover.
// Optional BCD outputs (tens/ones) are enabled by defining DIGITS_TIMER_BCD_OUT_EN.
module digits_timer #(
  parameter int WIDTH       = 7,
  parameter int MAX         = 99,
  parameter int BUZZ_CYCLES = 1
) (
  input  logic             clk_1Hz,
  input  logic             result_reset_n,
  input  logic             updown,
  input  logic             result_load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             state,
  output logic [WIDTH-1:0] count,
  output logic             buzzer,
  output logic             wrap
`ifdef DIGITS_TIMER_BCD_OUT_EN
  ,
  output logic [3:0]       tens,
  output logic [3:0]       ones
`endif
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam int AW = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(BUZZ_CYCLES - 1);

  typedef enum logic [1:0] {RUN, HOLD, ALARM} fsm_t;

  fsm_t             fsm;
  logic [AW-1:0]    alarm_cnt;
  logic [WIDTH-1:0] count_nxt;
  logic             counting;
  logic             at_terminal;
  logic             roll;

  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
    return (v > MAX_W) ? MAX_W : v;
  endfunction

`ifdef DIGITS_TIMER_BCD_OUT_EN
  function automatic logic [3:0] bcd_tens(input logic [WIDTH-1:0] v);
    return 4'(int'(v) / 10);
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [WIDTH-1:0] v);
    return 4'(int'(v) % 10);
  endfunction
`endif

  assign counting    = result_reset_n && !result_load && (fsm == RUN) && !state;
  assign at_terminal = updown ? (count == '0) : (count == MAX_W);
  assign roll        = counting && at_terminal;

  always_comb begin
    count_nxt = count;
    if (!result_reset_n) begin
      count_nxt = updown ? MAX_W : '0;
    end else if (result_load) begin
      count_nxt = sat_load(load_val);
    end else if (counting) begin
      if (!updown) count_nxt = at_terminal ? '0 : count + WIDTH'(1);
      else         count_nxt = at_terminal ? MAX_W : count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_1Hz) begin
    count <= count_nxt;
`ifdef DIGITS_TIMER_BCD_OUT_EN
    tens  <= bcd_tens(count_nxt);
    ones  <= bcd_ones(count_nxt);
`endif
    if (!result_reset_n) begin
      fsm       <= RUN;
      buzzer    <= 1'b0;
      wrap      <= 1'b0;
      alarm_cnt <= '0;
    end else if (result_load) begin
      // a load also aborts a running alarm and never counts as a rollover
      fsm       <= state ? HOLD : RUN;
      buzzer    <= 1'b0;
      wrap      <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      wrap <= roll;
      case (fsm)
        ALARM: begin
          if (alarm_cnt == ALARM_LAST) begin
            buzzer    <= 1'b0;
            alarm_cnt <= '0;
            fsm       <= state ? HOLD : RUN;
          end else begin
            alarm_cnt <= alarm_cnt + AW'(1);
          end
        end
        HOLD: begin
          if (!state) fsm <= RUN;
        end
        default: begin
          if (state) begin
            fsm <= HOLD;
          end else if (roll) begin
            fsm       <= ALARM;
            buzzer    <= 1'b1;
            alarm_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digits_timer.sv
// Scoreboard bench for digits_timer: a behavioural model queues the expected outputs
// per edge and a negedge monitor pops and compares them.
module tb_digits_timer;
  localparam int WIDTH = 7;
  localparam int MAX   = 99;
  localparam int BUZZ  = 3;

  logic             clk_1Hz = 1'b0;
  logic             result_reset_n = 1'b0;
  logic             updown = 1'b0;
  logic             result_load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             state = 1'b0;
  logic [WIDTH-1:0] count;
  logic             buzzer;
  logic             wrap;
`ifdef DIGITS_TIMER_BCD_OUT_EN
  logic [3:0]       tens;
  logic [3:0]       ones;
`endif

  digits_timer #(.WIDTH(WIDTH), .MAX(MAX), .BUZZ_CYCLES(BUZZ)) dut (
    .clk_1Hz(clk_1Hz),
    .result_reset_n(result_reset_n),
    .updown(updown),
    .result_load(result_load),
    .load_val(load_val),
    .state(state),
    .count(count),
    .buzzer(buzzer),
    .wrap(wrap)
`ifdef DIGITS_TIMER_BCD_OUT_EN
    ,
    .tens(tens),
    .ones(ones)
`endif
  );

  always #5 clk_1Hz = ~clk_1Hz;

  typedef struct {
    int cnt;
    int buzz;
    int wr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: remaining alarm clocks, hold flag, current count
  int m_count = 0;
  int m_alarm = 0;
  bit m_hold  = 0;

  task automatic model_edge(input bit rn, input bit ld, input int lv, input bit ud, input bit st);
    exp_t e;
    int wr;
    wr = 0;
    if (!rn) begin
      m_count = ud ? MAX : 0;
      m_alarm = 0;
      m_hold  = 0;
    end else if (ld) begin
      m_count = (lv > MAX) ? MAX : lv;
      m_alarm = 0;
      m_hold  = st;
    end else if (m_alarm > 0) begin
      m_alarm = m_alarm - 1;
      if (m_alarm == 0) m_hold = st;
    end else if (m_hold) begin
      m_hold = st;
    end else if (st) begin
      m_hold = 1;
    end else if (!ud) begin
      if (m_count == MAX) begin
        m_count = 0; wr = 1; m_alarm = BUZZ;
      end else m_count = m_count + 1;
    end else begin
      if (m_count == 0) begin
        m_count = MAX; wr = 1; m_alarm = BUZZ;
      end else m_count = m_count - 1;
    end
    e.cnt  = m_count;
    e.buzz = (m_alarm > 0) ? 1 : 0;
    e.wr   = wr;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit rn, input bit ld, input int lv, input bit ud, input bit st);
    result_reset_n = rn;
    result_load    = ld;
    load_val       = WIDTH'(lv);
    updown         = ud;
    state          = st;
    model_edge(rn, ld, lv, ud, st);
    @(posedge clk_1Hz);
    #1;
  endtask

  always @(negedge clk_1Hz) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (int'(count) !== e.cnt) begin
        errors++;
        $display("FAIL count: got %0d expected %0d at %0t", count, e.cnt, $time);
      end
      checks++;
      if (int'(buzzer) !== e.buzz) begin
        errors++;
        $display("FAIL buzzer: got %0b expected %0d at %0t", buzzer, e.buzz, $time);
      end
      checks++;
      if (int'(wrap) !== e.wr) begin
        errors++;
        $display("FAIL wrap: got %0b expected %0d at %0t", wrap, e.wr, $time);
      end
`ifdef DIGITS_TIMER_BCD_OUT_EN
      checks++;
      if (int'(tens) !== e.cnt / 10 || int'(ones) !== e.cnt % 10) begin
        errors++;
        $display("FAIL bcd: got %0d%0d expected %0d at %0t", tens, ones, e.cnt, $time);
      end
`endif
    end
  end

  initial begin
    int guard;
    bit ud;
    // up-count rollover through a full alarm
    step(0, 0, 0, 0, 0);
    step(1, 1, 98, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
    // down-count rollover, hold requested during alarm
    step(0, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    // saturating load, load aborting an alarm, hold, reset beating load
    step(1, 1, 120, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 42, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
    step(0, 1, 77, 0, 0);
    step(1, 1, 57, 0, 0);
    step(1, 0, 0, 0, 0);
    // randomized traffic, biased toward terminal counts
    ud = 0;
    for (int i = 0; i < 600; i++) begin
      bit rn, ld, st;
      int lv;
      if ($urandom_range(0, 19) == 0) ud = ~ud;
      rn = ($urandom_range(0, 59) != 0);
      ld = ($urandom_range(0, 11) == 0);
      st = ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 3))
        0: lv = 0;
        1: lv = MAX;
        2: lv = $urandom_range(MAX - 3, 127);
        default: lv = $urandom_range(0, 127);
      endcase
      step(rn, ld, lv, ud, st);
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk_1Hz);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
